// File: rtl/time_zone_applier_if.sv
// Signal bundle between the time-zone display datapath and its consumers:
// base calendar time plus offset in, zone-adjusted calendar time out.
interface time_zone_applier_if;
  logic [4:0] Hours;
  logic [4:0] Day;
  logic [3:0] Month;
  logic [6:0] Year;
  logic [6:0] TZHours;
  logic       TZPlusMinus;
  logic [4:0] LocalHours;
  logic [4:0] LocalDay;
  logic [3:0] LocalMonth;
  logic [6:0] LocalYear;
  logic       Valid;
  logic       Busy;

  modport master (
    output Hours, Day, Month, Year, TZHours, TZPlusMinus,
    input  LocalHours, LocalDay, LocalMonth, LocalYear, Valid, Busy
  );

  modport slave (
    input  Hours, Day, Month, Year, TZHours, TZPlusMinus,
    output LocalHours, LocalDay, LocalMonth, LocalYear, Valid, Busy
  );
endinterface

// File: rtl/time_zone_applier.sv
// Applies a signed whole-hour time-zone offset to the base time and date,
// recomputing through IDLE -> LATCH -> CALC -> ADJ -> OUT whenever an input moves.
module time_zone_applier #(
  parameter int TZ_MAX   = 12,
  parameter int YEAR_MAX = 99
) (
  input  logic                 clk,
  input  logic                 reset,
  time_zone_applier_if.slave   tz
);

  localparam logic [6:0] TZ_MAX_W   = 7'(TZ_MAX);
  localparam logic [6:0] YEAR_MAX_W = 7'(YEAR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CALC,
    S_ADJ,
    S_OUT
  } state_t;

  typedef enum logic [1:0] {
    CARRY_NONE,
    CARRY_INC,
    CARRY_DEC
  } carry_t;

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic [6:0] year);
    logic [4:0] len;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  state_t     state_q, state_d;

  logic       stale_q, stale_d;
  logic [4:0] snap_hours_q, snap_hours_d;
  logic [4:0] snap_day_q, snap_day_d;
  logic [3:0] snap_month_q, snap_month_d;
  logic [6:0] snap_year_q, snap_year_d;
  logic [6:0] snap_tz_q, snap_tz_d;
  logic       snap_sign_q, snap_sign_d;

  logic [4:0] calc_hours_q, calc_hours_d;
  carry_t     carry_q, carry_d;

  logic [4:0] adj_day_q, adj_day_d;
  logic [3:0] adj_month_q, adj_month_d;
  logic [6:0] adj_year_q, adj_year_d;

  logic [4:0] local_hours_q, local_hours_d;
  logic [4:0] local_day_q, local_day_d;
  logic [3:0] local_month_q, local_month_d;
  logic [6:0] local_year_q, local_year_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic [6:0]        tz_clamped;
  logic              inputs_differ;
  logic signed [7:0] sum_s;
  logic [4:0]        cur_len;
  logic [3:0]        prev_month;
  logic [6:0]        prev_year;
  logic [4:0]        prev_len;

  // The snapshot holds the clamped offset, so the comparison must clamp too;
  // otherwise an oversized TZHours would look like a change forever.
  assign tz_clamped    = (tz.TZHours > TZ_MAX_W) ? TZ_MAX_W : tz.TZHours;
  assign inputs_differ = {tz.Hours, tz.Day, tz.Month, tz.Year, tz_clamped, tz.TZPlusMinus}
                      != {snap_hours_q, snap_day_q, snap_month_q, snap_year_q, snap_tz_q, snap_sign_q};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (stale_q || inputs_differ) state_d = S_LATCH;
      S_LATCH: state_d = S_CALC;
      S_CALC:  state_d = S_ADJ;
      S_ADJ:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic
  // NOTE: every signal gets a hold default before the case, so no path can infer a latch.
  always_comb begin
    stale_d       = stale_q && (state_q != S_LATCH);
    snap_hours_d  = snap_hours_q;
    snap_day_d    = snap_day_q;
    snap_month_d  = snap_month_q;
    snap_year_d   = snap_year_q;
    snap_tz_d     = snap_tz_q;
    snap_sign_d   = snap_sign_q;
    calc_hours_d  = calc_hours_q;
    carry_d       = carry_q;
    adj_day_d     = adj_day_q;
    adj_month_d   = adj_month_q;
    adj_year_d    = adj_year_q;
    local_hours_d = local_hours_q;
    local_day_d   = local_day_q;
    local_month_d = local_month_q;
    local_year_d  = local_year_q;
    valid_d       = valid_q;
    busy_d        = (state_q == S_LATCH) || (state_q == S_CALC) || (state_q == S_ADJ);

    // Eight bits signed keeps 23+12 and 0-12 (and garbage hours) free of overflow.
    sum_s = snap_sign_q ? ($signed({3'b000, snap_hours_q}) + $signed({1'b0, snap_tz_q}))
                        : ($signed({3'b000, snap_hours_q}) - $signed({1'b0, snap_tz_q}));

    cur_len    = month_len(snap_month_q, snap_year_q);
    prev_month = (snap_month_q == 4'd1) ? 4'd12 : snap_month_q - 4'd1;
    prev_year  = (snap_month_q != 4'd1) ? snap_year_q
               : (snap_year_q == 7'd0)  ? YEAR_MAX_W : snap_year_q - 7'd1;
    prev_len   = month_len(prev_month, prev_year);

    case (state_q)
      S_LATCH: begin
        snap_hours_d = tz.Hours;
        snap_day_d   = tz.Day;
        snap_month_d = tz.Month;
        snap_year_d  = tz.Year;
        snap_tz_d    = tz_clamped;
        snap_sign_d  = tz.TZPlusMinus;
      end

      S_CALC: begin
        if (sum_s >= 8'sd24) begin
          calc_hours_d = 5'(sum_s - 8'sd24);
          carry_d      = CARRY_INC;
        end else if (sum_s < 8'sd0) begin
          calc_hours_d = 5'(sum_s + 8'sd24);
          carry_d      = CARRY_DEC;
        end else begin
          calc_hours_d = 5'(sum_s);
          carry_d      = CARRY_NONE;
        end
      end

      S_ADJ: begin
        adj_day_d   = snap_day_q;
        adj_month_d = snap_month_q;
        adj_year_d  = snap_year_q;
        case (carry_q)
          CARRY_INC: begin
            if (snap_day_q == cur_len) begin
              adj_day_d = 5'd1;
              if (snap_month_q == 4'd12) begin
                adj_month_d = 4'd1;
                adj_year_d  = (snap_year_q >= YEAR_MAX_W) ? 7'd0 : snap_year_q + 7'd1;
              end else begin
                adj_month_d = snap_month_q + 4'd1;
              end
            end else begin
              adj_day_d = snap_day_q + 5'd1;
            end
          end
          CARRY_DEC: begin
            if (snap_day_q == 5'd1) begin
              adj_day_d   = prev_len;
              adj_month_d = prev_month;
              adj_year_d  = prev_year;
            end else begin
              adj_day_d = snap_day_q - 5'd1;
            end
          end
          default: ;
        endcase
      end

      S_OUT: begin
        local_hours_d = calc_hours_q;
        local_day_d   = adj_day_q;
        local_month_d = adj_month_q;
        local_year_d  = adj_year_q;
        valid_d       = 1'b1;
      end

      default: ;
    endcase
  end

  // Datapath registers; stale is set by reset so one computation always follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stale_q       <= 1'b1;
      snap_hours_q  <= '0;
      snap_day_q    <= '0;
      snap_month_q  <= '0;
      snap_year_q   <= '0;
      snap_tz_q     <= '0;
      snap_sign_q   <= 1'b0;
      calc_hours_q  <= '0;
      carry_q       <= CARRY_NONE;
      adj_day_q     <= 5'd1;
      adj_month_q   <= 4'd1;
      adj_year_q    <= '0;
      local_hours_q <= '0;
      local_day_q   <= 5'd1;
      local_month_q <= 4'd1;
      local_year_q  <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      stale_q       <= stale_d;
      snap_hours_q  <= snap_hours_d;
      snap_day_q    <= snap_day_d;
      snap_month_q  <= snap_month_d;
      snap_year_q   <= snap_year_d;
      snap_tz_q     <= snap_tz_d;
      snap_sign_q   <= snap_sign_d;
      calc_hours_q  <= calc_hours_d;
      carry_q       <= carry_d;
      adj_day_q     <= adj_day_d;
      adj_month_q   <= adj_month_d;
      adj_year_q    <= adj_year_d;
      local_hours_q <= local_hours_d;
      local_day_q   <= local_day_d;
      local_month_q <= local_month_d;
      local_year_q  <= local_year_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
    end
  end

  assign tz.LocalHours = local_hours_q;
  assign tz.LocalDay   = local_day_q;
  assign tz.LocalMonth = local_month_q;
  assign tz.LocalYear  = local_year_q;
  assign tz.Valid      = valid_q;
  assign tz.Busy       = busy_q;

endmodule

// File: tb/tb_time_zone_applier.sv
// Scenario bench for time_zone_applier: expected results are queued when
// stimulus is driven and popped when the DUT publishes a result.
module tb_time_zone_applier;

  typedef struct packed {
    logic [4:0] h;
    logic [4:0] d;
    logic [3:0] m;
    logic [6:0] y;
  } exp_t;

  typedef struct packed {
    logic [4:0] h;
    logic [4:0] d;
    logic [3:0] m;
    logic [6:0] y;
    logic [6:0] tzh;
    logic       sgn;
    exp_t       e;
  } case_t;

  localparam exp_t RESET_VALS = '{h: 5'd0, d: 5'd1, m: 4'd1, y: 7'd0};

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last;

  time_zone_applier_if tzif ();

  time_zone_applier dut (
    .clk   (clk),
    .reset (reset),
    .tz    (tzif)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return '{h: tzif.LocalHours, d: tzif.LocalDay, m: tzif.LocalMonth, y: tzif.LocalYear};
  endfunction

  task automatic drive(input logic [4:0] h, input logic [4:0] d, input logic [3:0] m,
                       input logic [6:0] y, input logic [6:0] tzh, input logic sgn);
    tzif.Hours       = h;
    tzif.Day         = d;
    tzif.Month       = m;
    tzif.Year        = y;
    tzif.TZHours     = tzh;
    tzif.TZPlusMinus = sgn;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t o;
    reset = 1'b1;
    drive(5'd10, 5'd15, 4'd6, 7'd24, 7'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    o = observed();
    if (o !== RESET_VALS || tzif.Valid !== 1'b0 || tzif.Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %0d %0d/%0d/%0d v=%b b=%b, want 0 1/1/0 v=0 b=0",
               o.h, o.d, o.m, o.y, tzif.Valid, tzif.Busy);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{h: 5'd17, d: 5'd15, m: 4'd6, y: 7'd24});
    last = RESET_VALS;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (k < 5) begin
        o = observed();
        if (tzif.Busy !== (k >= 2) || tzif.Valid !== 1'b0 || o !== last) begin
          bad++;
          $display("FAIL first_wait k=%0d: got b=%b v=%b out=%0d %0d/%0d/%0d, want b=%b v=0 reset outputs",
                   k, tzif.Busy, tzif.Valid, o.h, o.d, o.m, o.y, (k >= 2));
        end
      end else begin
        e = sb.pop_front();
        o = observed();
        if (o !== e || tzif.Valid !== 1'b1 || tzif.Busy !== 1'b0) begin
          bad++;
          $display("FAIL first_result: got %0d %0d/%0d/%0d v=%b b=%b, want %0d %0d/%0d/%0d v=1 b=0",
                   o.h, o.d, o.m, o.y, tzif.Valid, tzif.Busy, e.h, e.d, e.m, e.y);
        end
        last = e;
      end
    end
  endtask

  task automatic test_offsets();
    case_t cases[$];
    exp_t  e;
    exp_t  o;
    cases.push_back('{h:20, d:31, m:12, y:99, tzh:7,   sgn:1, e:'{h:3,  d:1,  m:1,  y:0 }});
    cases.push_back('{h:12, d:28, m:2,  y:23, tzh:12,  sgn:1, e:'{h:0,  d:1,  m:3,  y:23}});
    cases.push_back('{h:2,  d:1,  m:3,  y:24, tzh:5,   sgn:0, e:'{h:21, d:29, m:2,  y:24}});
    cases.push_back('{h:2,  d:1,  m:3,  y:23, tzh:5,   sgn:0, e:'{h:21, d:28, m:2,  y:23}});
    cases.push_back('{h:2,  d:1,  m:5,  y:23, tzh:5,   sgn:0, e:'{h:21, d:30, m:4,  y:23}});
    cases.push_back('{h:0,  d:1,  m:1,  y:0,  tzh:12,  sgn:0, e:'{h:12, d:31, m:12, y:99}});
    cases.push_back('{h:0,  d:1,  m:1,  y:0,  tzh:0,   sgn:0, e:'{h:0,  d:1,  m:1,  y:0 }});
    cases.push_back('{h:0,  d:1,  m:1,  y:0,  tzh:0,   sgn:1, e:'{h:0,  d:1,  m:1,  y:0 }});
    cases.push_back('{h:5,  d:10, m:6,  y:24, tzh:13,  sgn:1, e:'{h:17, d:10, m:6,  y:24}});
    cases.push_back('{h:11, d:10, m:6,  y:24, tzh:100, sgn:1, e:'{h:23, d:10, m:6,  y:24}});
    cases.push_back('{h:5,  d:10, m:6,  y:24, tzh:5,   sgn:0, e:'{h:0,  d:10, m:6,  y:24}});
    foreach (cases[i]) begin
      @(negedge clk);
      drive(cases[i].h, cases[i].d, cases[i].m, cases[i].y, cases[i].tzh, cases[i].sgn);
      sb.push_back(cases[i].e);
      for (int k = 0; k <= 4; k++) begin
        @(posedge clk);
        #1;
        total++;
        o = observed();
        if (k < 4) begin
          if (tzif.Busy !== (k >= 1) || o !== last) begin
            bad++;
            $display("FAIL case%0d_wait k=%0d: got b=%b out=%0d %0d/%0d/%0d, want b=%b out=%0d %0d/%0d/%0d",
                     i, k, tzif.Busy, o.h, o.d, o.m, o.y, (k >= 1), last.h, last.d, last.m, last.y);
          end
        end else begin
          e = sb.pop_front();
          if (o !== e || tzif.Valid !== 1'b1 || tzif.Busy !== 1'b0) begin
            bad++;
            $display("FAIL case%0d_result: got %0d %0d/%0d/%0d v=%b b=%b, want %0d %0d/%0d/%0d v=1 b=0",
                     i, o.h, o.d, o.m, o.y, tzif.Valid, tzif.Busy, e.h, e.d, e.m, e.y);
          end
          last = e;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t o;
    @(negedge clk);
    drive(5'd10, 5'd15, 4'd6, 7'd24, 7'd1, 1'b1);
    sb.push_back('{h: 5'd11, d: 5'd15, m: 4'd6, y: 7'd24});
    repeat (2) @(posedge clk);
    @(negedge clk);
    tzif.Hours = 5'd11;
    sb.push_back('{h: 5'd12, d: 5'd15, m: 4'd6, y: 7'd24});
    // Edges 2..9 after the sampling edge; first result at 4, second 5 edges later.
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk);
      #1;
      total++;
      o = observed();
      if (k == 4 || k == 9) begin
        e = sb.pop_front();
        if (o !== e || tzif.Busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b_result k=%0d: got %0d %0d/%0d/%0d b=%b, want %0d %0d/%0d/%0d b=0",
                   k, o.h, o.d, o.m, o.y, tzif.Busy, e.h, e.d, e.m, e.y);
        end
        last = e;
      end else if (tzif.Busy !== (k != 5) || o !== last) begin
        bad++;
        $display("FAIL b2b_wait k=%0d: got b=%b out=%0d, want b=%b out=%0d",
                 k, tzif.Busy, o.h, (k != 5), last.h);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    exp_t e;
    exp_t o;
    @(negedge clk);
    drive(5'd3, 5'd15, 4'd6, 7'd24, 7'd1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    o = observed();
    if (o !== RESET_VALS || tzif.Valid !== 1'b0 || tzif.Busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: got %0d %0d/%0d/%0d v=%b b=%b, want 0 1/1/0 v=0 b=0",
               o.h, o.d, o.m, o.y, tzif.Valid, tzif.Busy);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{h: 5'd4, d: 5'd15, m: 4'd6, y: 7'd24});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      total++;
      o = observed();
      if (k < 5) begin
        if (tzif.Valid !== 1'b0 || tzif.Busy !== (k >= 2) || o !== RESET_VALS) begin
          bad++;
          $display("FAIL midreset_wait k=%0d: got v=%b b=%b out=%0d, want v=0 b=%b out=0",
                   k, tzif.Valid, tzif.Busy, o.h, (k >= 2));
        end
      end else begin
        e = sb.pop_front();
        if (o !== e || tzif.Valid !== 1'b1) begin
          bad++;
          $display("FAIL midreset_result: got %0d %0d/%0d/%0d v=%b, want %0d %0d/%0d/%0d v=1",
                   o.h, o.d, o.m, o.y, tzif.Valid, e.h, e.d, e.m, e.y);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_offsets();
    test_back_to_back();
    test_reset_mid_calc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
